// File: rtl/serial_core_pkg.sv
// Shared types and constants for the bit-serial RV32 R-type core sequencer.
package serial_core_pkg;

    localparam int XLEN = 32;

    // Instruction field LSB positions (RV32 R-type layout)
    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    // True when the word carries the register-register ALU opcode
    function automatic logic is_rtype(input logic [31:0] ins);
        return ins[OPC_LSB +: 7] == OPC_RTYPE;
    endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// 5-bit bit-cycle counter shared by the fetch and execute phases.
module serial_bit_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    output logic [4:0] cnt,
    output logic       last
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    // Next count: clear wins over increment; the natural 31->0 wrap lands on a phase boundary
    always_comb begin
        if (clr) begin
            cnt_d = 5'd0;
        end else if (en) begin
            cnt_d = cnt_q + 5'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == 5'd31);

endmodule

// File: rtl/serial_core_sequencer.sv
// Phase sequencer: fetches an instruction bit-serially, decodes it, and steps
// the serial datapath through 32 bit-cycles plus a write-back.
module serial_core_sequencer #(
    parameter int XLEN       = serial_core_pkg::XLEN,
    parameter int PROG_BYTES = 48,
    parameter int RESET_PC   = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            ins_bit,
    output logic [31:0]     pc,
    output logic [4:0]      bit_idx,
    output logic [XLEN-1:0] instr,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            exec_en,
    output logic            carry_clr,
    output logic            rf_we,
    output logic            illegal,
    output logic            done,
    output logic [2:0]      phase
);
    import serial_core_pkg::*;

    localparam logic [31:0] PC_INIT = 32'(RESET_PC);
    localparam logic [31:0] PC_END  = 32'(PROG_BYTES);

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            exec_q, exec_d;
    logic            cclr_q, cclr_d;
    logic            rfwe_q, rfwe_d;
    logic            ill_q, ill_d;
    logic            done_q, done_d;

    logic            cnt_en_s;
    logic            cnt_clr_s;
    logic            cnt_last_s;
    logic [4:0]      cnt_s;
    logic            bit_phase_s;

    assign bit_phase_s = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    assign cnt_en_s    = run && bit_phase_s;
    assign cnt_clr_s   = run && !bit_phase_s;

    serial_bit_counter u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en_s),
        .clr   (cnt_clr_s),
        .cnt   (cnt_s),
        .last  (cnt_last_s)
    );

    // Next-state, PC and instruction assembly; strobes are decoded from the next state
    // so each one is a flop that lines up exactly with the state it belongs to
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (run) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    instr_d[cnt_s] = ins_bit;
                    if (cnt_last_s) begin
                        state_d = ST_DECODE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    if (is_rtype(instr_q[31:0])) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
                ST_EXEC: begin
                    if (cnt_last_s) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_WB: begin
                    state_d = ST_NEXT;
                end
                ST_NEXT: begin
                    if ((pc_q + 32'd4) == PC_END) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = ST_FETCH;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        exec_d = (state_d == ST_EXEC);
        cclr_d = (state_d == ST_DECODE) && is_rtype(instr_d[31:0]);
        ill_d  = (state_d == ST_DECODE) && !is_rtype(instr_d[31:0]);
        rfwe_d = (state_d == ST_WB) && (instr_d[RD_LSB +: 5] != 5'd0);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            exec_q  <= 1'b0;
            cclr_q  <= 1'b0;
            rfwe_q  <= 1'b0;
            ill_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            exec_q  <= exec_d;
            cclr_q  <= cclr_d;
            rfwe_q  <= rfwe_d;
            ill_q   <= ill_d;
            done_q  <= done_d;
        end
    end

    assign pc      = pc_q;
    assign bit_idx = cnt_s;
    assign instr   = instr_q;
    assign rs1     = instr_q[RS1_LSB +: 5];
    assign rs2     = instr_q[RS2_LSB +: 5];
    assign rd      = instr_q[RD_LSB +: 5];
    assign funct3  = instr_q[F3_LSB +: 3];
    assign funct7  = instr_q[F7_LSB +: 7];
    assign phase   = state_q;
    assign done    = done_q;

    // A frozen cycle must never step or write the datapath, so strobes are gated by run
    assign exec_en   = exec_q & run;
    assign carry_clr = cclr_q & run;
    assign rf_we     = rfwe_q & run;
    assign illegal   = ill_q & run;

endmodule

// File: tb/tb_serial_core_sequencer.sv
// Scoreboard bench for the serial core sequencer.
module tb_serial_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        ins_bit;
    logic [31:0] pc;
    logic [4:0]  bit_idx;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        exec_en, carry_clr, rf_we, illegal, done;
    logic [2:0]  phase;

    serial_core_sequencer #(.XLEN(32), .PROG_BYTES(48), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .run(run), .ins_bit(ins_bit),
        .pc(pc), .bit_idx(bit_idx), .instr(instr),
        .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7),
        .exec_en(exec_en), .carry_clr(carry_clr), .rf_we(rf_we),
        .illegal(illegal), .done(done), .phase(phase)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:15];
    assign ins_bit = mem[pc[5:2]][bit_idx];

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          cyc, ex, we, cc, il;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_A = 32'h00730333; // add x6,x6,x7
    localparam logic [31:0] I_B = 32'h00000293; // addi x5,x0,0
    localparam logic [31:0] I_C = 32'h00000033; // add x0,x0,x0
    localparam logic [31:0] I_D = 32'h402081B3; // sub x3,x1,x2
    localparam logic [31:0] I_E = 32'h00C5C533; // xor x10,x11,x12

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] ins, input int idx, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] d, input logic [2:0] f3,
                        input logic [6:0] f7, input int cyc, input int ex, input int we,
                        input int cc, input int il);
        exp_t e;
        e.ins = ins; e.pc = 32'(idx * 4); e.rs1 = r1; e.rs2 = r2; e.rd = d;
        e.f3 = f3; e.f7 = f7; e.cyc = cyc; e.ex = ex; e.we = we; e.cc = cc; e.il = il;
        mem[idx] = ins;
        sb.push_back(e);
    endtask

    // Monitor state: per-instruction observations
    int          m_cyc, m_ex, m_we, m_cc, m_il;
    logic [31:0] m_ins;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    exp_t        m_e;

    always @(negedge clk) begin
        if (phase == 3'd0) begin
            m_cyc = 0; m_ex = 0; m_we = 0; m_cc = 0; m_il = 0;
        end else if (phase == 3'd5 && run) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_instr: got pc %0h want none", pc);
            end else begin
                m_e = sb.pop_front();
                chk("pc", pc, m_e.pc);
                chk("instr", m_ins, m_e.ins);
                chk("rs1", 32'(m_rs1), 32'(m_e.rs1));
                chk("rs2", 32'(m_rs2), 32'(m_e.rs2));
                chk("rd", 32'(m_rd), 32'(m_e.rd));
                chk("funct3", 32'(m_f3), 32'(m_e.f3));
                chk("funct7", 32'(m_f7), 32'(m_e.f7));
                chk("cycles", 32'(m_cyc + 1), 32'(m_e.cyc));
                chk("exec_cnt", 32'(m_ex), 32'(m_e.ex));
                chk("rf_we_cnt", 32'(m_we), 32'(m_e.we));
                chk("carry_clr_cnt", 32'(m_cc), 32'(m_e.cc));
                chk("illegal_cnt", 32'(m_il), 32'(m_e.il));
            end
            m_cyc = 0; m_ex = 0; m_we = 0; m_cc = 0; m_il = 0;
        end else if (phase >= 3'd1 && phase <= 3'd4) begin
            m_cyc++;
            if (exec_en)   m_ex++;
            if (rf_we)     m_we++;
            if (carry_clr) m_cc++;
            if (illegal)   m_il++;
            if (phase == 3'd2 && run) begin
                m_ins = instr; m_rs1 = rs1; m_rs2 = rs2; m_rd = rd;
                m_f3 = funct3; m_f7 = funct7;
            end
        end
    end

    initial begin
        logic [31:0] dv;
        logic        paused;
        dv     = I_D;
        paused = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        //   ins  idx rs1    rs2    rd     f3    f7       cyc ex  we cc il
        push(I_A, 0,  5'd6,  5'd7,  5'd6,  3'd0, 7'd0,    67, 32, 1, 1, 0);
        push(I_B, 1,  5'd0,  5'd0,  5'd5,  3'd0, 7'd0,    34, 0,  0, 0, 1);
        push(I_C, 2,  5'd0,  5'd0,  5'd0,  3'd0, 7'd0,    67, 32, 0, 1, 0);
        push(I_D, 3,  5'd1,  5'd2,  5'd3,  3'd0, 7'h20,   72, 32, 1, 1, 0);
        push(I_E, 4,  5'd11, 5'd12, 5'd10, 3'd4, 7'd0,    67, 32, 1, 1, 0);
        push(I_A, 5,  5'd6,  5'd7,  5'd6,  3'd0, 7'd0,    67, 32, 1, 1, 0);
        push(I_D, 6,  5'd1,  5'd2,  5'd3,  3'd0, 7'h20,   67, 32, 1, 1, 0);
        push(I_E, 7,  5'd11, 5'd12, 5'd10, 3'd4, 7'd0,    67, 32, 1, 1, 0);
        push(I_A, 8,  5'd6,  5'd7,  5'd6,  3'd0, 7'd0,    67, 32, 1, 1, 0);
        push(I_D, 9,  5'd1,  5'd2,  5'd3,  3'd0, 7'h20,   67, 32, 1, 1, 0);
        push(I_E, 10, 5'd11, 5'd12, 5'd10, 3'd4, 7'd0,    67, 32, 1, 1, 0);
        push(I_A, 11, 5'd6,  5'd7,  5'd6,  3'd0, 7'd0,    67, 32, 1, 1, 0);

        // Reset state, with run already high
        reset = 1'b1;
        run   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_bit_idx", 32'(bit_idx), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_strobes", {28'd0, exec_en, carry_clr, rf_we, illegal}, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Abort the first instruction with reset at EXEC bit 20
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (phase == 3'd3 && bit_idx == 5'd20) break;
        end
        chk("reach_exec20", {27'd0, phase, bit_idx[1:0]}, {27'd0, 3'd3, 2'd0});
        chk("exec_en_mid", 32'(exec_en), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_phase", 32'(phase), 32'd0);
        chk("abort_pc", pc, 32'd0);
        chk("abort_instr", instr, 32'd0);
        chk("abort_exec_en", 32'(exec_en), 32'd0);
        chk("abort_bit_idx", 32'(bit_idx), 32'd0);

        // Full program, with a 5-cycle pause at FETCH bit 10 of the instruction at pc 12
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk);
            #1;
            if (!paused && pc == 32'd12 && phase == 3'd1 && bit_idx == 5'd10) begin
                paused = 1'b1;
                run    = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    chk("pause_bit_idx", 32'(bit_idx), 32'd10);
                    chk("pause_instr_lo", {22'd0, instr[9:0]}, {22'd0, dv[9:0]});
                    chk("pause_phase", 32'(phase), 32'd1);
                    @(posedge clk);
                    #1;
                end
                chk("resume_bit_idx", 32'(bit_idx), 32'd10);
                run = 1'b1;
            end
        end
        chk("pause_seen", 32'(paused), 32'd1);
        chk("done_reached", 32'(done), 32'd1);
        chk("done_pc", pc, 32'd44);
        chk("done_phase", 32'(phase), 32'd6);

        // DONE must hold for 100 more cycles with no strobes
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_pc", pc, 32'd44);
            chk("hold_strobes", {28'd0, exec_en, carry_clr, rf_we, illegal}, 32'd0);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
